// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard controller: per-operand EX forwarding selects, a retired-write
// bypass register, and a load-use stall FSM with a stall-cycle counter.
module hazard_forward_ctrl #(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic [NUM_SRC*AW-1:0]  id_rs,
   input  logic [NUM_SRC-1:0]     id_rs_used,
   input  logic [NUM_SRC*AW-1:0]  ex_rs,
   input  logic [AW-1:0]          ex_rd,
   input  logic                   ex_regwrite,
   input  logic                   ex_memread,
   input  logic [AW-1:0]          mem_rd,
   input  logic                   mem_regwrite,
   input  logic [AW-1:0]          wb_rd,
   input  logic                   wb_regwrite,
   input  logic [XLEN-1:0]        wb_data,
   output logic [NUM_SRC*2-1:0]   fwd_sel,
   output logic [XLEN-1:0]        bypass_data,
   output logic                   stall_pc,
   output logic                   stall_ifid,
   output logic                   bubble_idex,
   output logic [CNT_W-1:0]       stall_cnt
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_STALL = 1'b1
   } state_t;

   localparam int CW = 2;
   // Remaining STALL cycles after the first (IDLE) stall cycle, minus one.
   localparam logic [CW-1:0] CNT_INIT = (LOAD_LAT > 1) ? CW'(LOAD_LAT - 2) : '0;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ret_valid_q, ret_valid_d;
   logic [AW-1:0]     ret_rd_q, ret_rd_d;
   logic [XLEN-1:0]   bypass_data_q, bypass_data_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic [NUM_SRC-1:0] src_hit;
   logic               hazard;
   logic               stall;

   logic mem_fwd_ok, wb_fwd_ok, ret_fwd_ok;
   assign mem_fwd_ok = mem_regwrite && (mem_rd != '0);
   assign wb_fwd_ok  = wb_regwrite && (wb_rd != '0);
   assign ret_fwd_ok = ret_valid_q && (ret_rd_q != '0);

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic [AW-1:0] ers;
         logic [AW-1:0] irs;
         logic [1:0]    sel;

         assign ers = ex_rs[gi*AW +: AW];
         assign irs = id_rs[gi*AW +: AW];

         // Youngest producer wins: EX/MEM, then MEM/WB, then the retired write.
         always_comb begin
            sel = 2'b00;
            if (mem_fwd_ok && (mem_rd == ers)) begin
               sel = 2'b10;
            end else if (wb_fwd_ok && (wb_rd == ers)) begin
               sel = 2'b01;
            end else if (ret_fwd_ok && (ret_rd_q == ers)) begin
               sel = 2'b11;
            end
         end

         assign fwd_sel[gi*2 +: 2] = sel;
         assign src_hit[gi]        = id_rs_used[gi] && (irs == ex_rd);
      end
   endgenerate

   assign hazard = ex_memread && ex_regwrite && (ex_rd != '0) && (|src_hit);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (hazard) begin
                  stall = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_d = S_STALL;
                     cnt_d   = CNT_INIT;
                  end
               end
            end
            S_STALL: begin
               stall = 1'b1;
               if (cnt_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // The retired write survives flush: the register file write has already happened.
   always_comb begin
      ret_valid_d   = ret_valid_q;
      ret_rd_d      = ret_rd_q;
      bypass_data_d = bypass_data_q;
      if (wb_fwd_ok) begin
         ret_valid_d   = 1'b1;
         ret_rd_d      = wb_rd;
         bypass_data_d = wb_data;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         ret_valid_q   <= 1'b0;
         ret_rd_q      <= '0;
         bypass_data_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ret_valid_q   <= ret_valid_d;
         ret_rd_q      <= ret_rd_d;
         bypass_data_q <= bypass_data_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign stall_pc    = stall;
   assign stall_ifid  = stall;
   assign bubble_idex = stall;
   assign bypass_data = bypass_data_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: a combinational vector table plus
// hand-written multi-cycle sequences on three instances (LOAD_LAT 1, 2, 3).
module tb_hazard_forward_ctrl;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NS   = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic [NS*AW-1:0]  id_rs;
   logic [NS-1:0]     id_rs_used;
   logic [NS*AW-1:0]  ex_rs;
   logic [AW-1:0]     ex_rd;
   logic              ex_regwrite, ex_memread;
   logic [AW-1:0]     mem_rd;
   logic              mem_regwrite;
   logic [AW-1:0]     wb_rd;
   logic              wb_regwrite;
   logic [XLEN-1:0]   wb_data;

   logic [NS*2-1:0]   fwd1, fwd2, fwd3;
   logic [XLEN-1:0]   byp1, byp2, byp3;
   logic              spc1, sif1, bub1, spc2, sif2, bub2, spc3, sif3, bub3;
   logic [3:0]        cnt1;
   logic [31:0]       cnt2, cnt3;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   hazard_forward_ctrl #(.XLEN(XLEN), .AW(AW), .NUM_SRC(NS), .LOAD_LAT(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .wb_data(wb_data), .fwd_sel(fwd1), .bypass_data(byp1), .stall_pc(spc1),
      .stall_ifid(sif1), .bubble_idex(bub1), .stall_cnt(cnt1));

   hazard_forward_ctrl #(.XLEN(XLEN), .AW(AW), .NUM_SRC(NS), .LOAD_LAT(2), .CNT_W(32)) dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .wb_data(wb_data), .fwd_sel(fwd2), .bypass_data(byp2), .stall_pc(spc2),
      .stall_ifid(sif2), .bubble_idex(bub2), .stall_cnt(cnt2));

   hazard_forward_ctrl #(.XLEN(XLEN), .AW(AW), .NUM_SRC(NS), .LOAD_LAT(3), .CNT_W(32)) dut3 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .wb_data(wb_data), .fwd_sel(fwd3), .bypass_data(byp3), .stall_pc(spc3),
      .stall_ifid(sif3), .bubble_idex(bub3), .stall_cnt(cnt3));

   typedef struct packed {
      logic [AW-1:0] ex_rs0;
      logic [AW-1:0] ex_rs1;
      logic [AW-1:0] mem_rd;
      logic          mem_rw;
      logic [AW-1:0] wb_rd;
      logic          wb_rw;
      logic [AW-1:0] id_rs0;
      logic [AW-1:0] id_rs1;
      logic [1:0]    id_used;
      logic [AW-1:0] ex_rd;
      logic          ex_mr;
      logic          ex_rw;
      logic          flush;
      logic [3:0]    exp_fwd;
      logic          exp_stall;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic quiet();
      flush = 0; id_rs = '0; id_rs_used = '0; ex_rs = '0; ex_rd = '0;
      ex_regwrite = 0; ex_memread = 0; mem_rd = '0; mem_regwrite = 0;
      wb_rd = '0; wb_regwrite = 0; wb_data = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      quiet();
      rst_n = 0;
      #2;
      rst_n = 1;
   endtask

   // Load to x7 in EX, decode consumer reads x7 on operand 1.
   task automatic drive_hazard();
      quiet();
      ex_rd = 5'd7; ex_memread = 1; ex_regwrite = 1;
      id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
   endtask

   initial begin
      vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 0};
      vecs[1]  = '{5, 0, 5, 1, 5, 1, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0010, 0};
      vecs[2]  = '{5, 0, 5, 0, 5, 1, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0001, 0};
      vecs[3]  = '{0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 0};
      vecs[4]  = '{3, 9, 9, 1, 3, 1, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1001, 0};
      vecs[5]  = '{0, 4, 4, 0, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 0};
      vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 7, 2'b10, 7, 1, 1, 0, 4'b0000, 1};
      vecs[7]  = '{0, 0, 0, 0, 0, 0, 7, 2, 2'b10, 7, 1, 1, 0, 4'b0000, 0};
      vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 7, 2'b10, 7, 1, 1, 1, 4'b0000, 0};
      vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 1, 1, 0, 4'b0000, 0};
      vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 7, 2'b10, 7, 1, 0, 0, 4'b0000, 0};
      vecs[11] = '{0, 0, 0, 0, 0, 0, 7, 0, 2'b01, 7, 1, 1, 0, 4'b0000, 1};

      // Combinational table runs under reset so the retired register stays empty.
      quiet();
      rst_n = 0;
      #2;
      for (int i = 0; i < 12; i++) begin
         ex_rs        = {vecs[i].ex_rs1, vecs[i].ex_rs0};
         mem_rd       = vecs[i].mem_rd;
         mem_regwrite = vecs[i].mem_rw;
         wb_rd        = vecs[i].wb_rd;
         wb_regwrite  = vecs[i].wb_rw;
         id_rs        = {vecs[i].id_rs1, vecs[i].id_rs0};
         id_rs_used   = vecs[i].id_used;
         ex_rd        = vecs[i].ex_rd;
         ex_memread   = vecs[i].ex_mr;
         ex_regwrite  = vecs[i].ex_rw;
         flush        = vecs[i].flush;
         #2;
         chk($sformatf("vec%0d fwd_sel", i), 64'(fwd1), 64'(vecs[i].exp_fwd));
         chk($sformatf("vec%0d stall", i), 64'({spc1, sif1, bub1}), 64'({3{vecs[i].exp_stall}}));
      end
      quiet();
      #2;
      chk("reset stall_cnt", 64'(cnt1), 64'd0);
      chk("reset bypass_data", 64'(byp1), 64'd0);
      chk("reset fwd_sel", 64'(fwd1), 64'd0);
      chk("reset stall", 64'({spc1, sif1, bub1}), 64'd0);

      // Load-use with LOAD_LAT=1
      step(); rst_n = 1;
      step(); drive_hazard();
      @(negedge clk); chk("L1 stall cyc1", 64'({spc1, sif1, bub1}), 64'b111);
      step(); quiet(); mem_rd = 7; mem_regwrite = 1; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
      @(negedge clk); chk("L1 stall cyc2", 64'(spc1), 64'd0);
      chk("L1 stall_cnt", 64'(cnt1), 64'd1);
      step(); quiet(); ex_rs = {5'd7, 5'd0}; wb_rd = 7; wb_regwrite = 1; wb_data = 32'h0000_00AA;
      @(negedge clk); chk("L1 fwd_sel op1", 64'(fwd1[3:2]), 64'b01);
      chk("L1 stall_cnt after", 64'(cnt1), 64'd1);

      // Load-use with LOAD_LAT=2, consumer reaches EX after the write retired
      step(); pulse_reset();
      step(); drive_hazard();
      @(negedge clk); chk("L2 stall cyc1", 64'({spc2, sif2, bub2}), 64'b111);
      step(); quiet(); mem_rd = 7; mem_regwrite = 1; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
      @(negedge clk); chk("L2 stall cyc2", 64'({spc2, sif2, bub2}), 64'b111);
      step(); quiet(); wb_rd = 7; wb_regwrite = 1; wb_data = 32'hDEADBEEF;
      id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
      @(negedge clk); chk("L2 stall cyc3", 64'(spc2), 64'd0);
      chk("L2 stall_cnt", 64'(cnt2), 64'd2);
      step(); quiet(); ex_rs = {5'd7, 5'd0};
      @(negedge clk); chk("L2 fwd_sel op1", 64'(fwd2[3:2]), 64'b11);
      chk("L2 bypass_data", 64'(byp2), 64'hDEADBEEF);

      // Flush in the second stall cycle, LOAD_LAT=3
      step(); pulse_reset();
      step(); drive_hazard();
      @(negedge clk); chk("L3 stall cyc1", 64'({spc3, sif3, bub3}), 64'b111);
      step(); drive_hazard(); flush = 1;
      @(negedge clk); chk("flush stall outs", 64'({spc3, sif3, bub3}), 64'b000);
      chk("flush stall_cnt", 64'(cnt3), 64'd1);
      step(); quiet();
      @(negedge clk); chk("after flush idle", 64'(spc3), 64'd0);
      chk("after flush stall_cnt", 64'(cnt3), 64'd1);

      // Asynchronous reset in the middle of a stall
      step(); pulse_reset();
      step(); wb_rd = 3; wb_regwrite = 1; wb_data = 32'h0000_1234;
      step(); drive_hazard();
      @(negedge clk); chk("pre-reset bypass", 64'(byp3), 64'h1234);
      step(); quiet();
      @(negedge clk); chk("pre-reset stalling", 64'(spc3), 64'd1);
      #1 rst_n = 0;
      #1;
      chk("async reset stall outs", 64'({spc3, sif3, bub3}), 64'b000);
      chk("async reset stall_cnt", 64'(cnt3), 64'd0);
      chk("async reset bypass", 64'(byp3), 64'd0);
      step(); rst_n = 1;

      // 16 single-cycle stalls wrap a 4-bit counter
      for (int i = 0; i < 16; i++) begin
         step(); drive_hazard();
         step(); quiet();
         @(negedge clk);
         if (i == 14) chk("cnt wrap at 15", 64'(cnt1), 64'd15);
         if (i == 15) chk("cnt wrap at 16", 64'(cnt1), 64'd0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
